// File: rtl/operand_loader.sv
// Operand entry stage for the 4-bit AND array: synchronizes switches and a bouncy
// load button, then captures two operands on successive debounced presses.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       sw,
  input  logic             load_btn,
  input  logic             clear,
  output logic [3:0]       op1,
  output logic [3:0]       op2,
  output logic             ops_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] pair_cnt
);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    HOLD   = 2'b10
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]      sw_m;
  logic [3:0]      sw_s;
  logic            btn_m;
  logic            btn_s;
  logic            deb;
  logic            deb_q;
  logic            press;
  logic [DB_W-1:0] db_cnt;
  state_t          st;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_m  <= 4'b0000;
      sw_s  <= 4'b0000;
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sw_m  <= sw;
      sw_s  <= sw_m;
      btn_m <= load_btn;
      btn_s <= btn_m;
    end
  end

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb    <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s != deb) begin
      if (db_cnt == DB_LAST) begin
        deb    <= ~deb;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Registered rising-edge pulse of the debounced level; falling edges are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b0;
      press <= 1'b0;
    end else begin
      deb_q <= deb;
      press <= deb & ~deb_q;
    end
  end

  // Operand FSM; clear wins over a coincident press and leaves pair_cnt alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= LOAD_A;
      op1       <= 4'b0000;
      op2       <= 4'b0000;
      ops_valid <= 1'b0;
      pair_cnt  <= '0;
    end else if (clear) begin
      st        <= LOAD_A;
      op1       <= 4'b0000;
      op2       <= 4'b0000;
      ops_valid <= 1'b0;
    end else if (press) begin
      case (st)
        LOAD_A, HOLD: begin
          op1       <= sw_s;
          op2       <= 4'b0000;
          ops_valid <= 1'b0;
          st        <= LOAD_B;
        end
        LOAD_B: begin
          op2       <= sw_s;
          ops_valid <= 1'b1;
          pair_cnt  <= pair_cnt + 1'b1;
          st        <= HOLD;
        end
        default: begin
          op1       <= 4'b0000;
          op2       <= 4'b0000;
          ops_valid <= 1'b0;
          st        <= LOAD_A;
        end
      endcase
    end
  end

  assign state = st;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with DEBOUNCE_CYCLES=4 and CNT_W=4.
module tb_operand_loader;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       load_btn;
  logic       clear;
  logic [3:0] op1;
  logic [3:0] op2;
  logic       ops_valid;
  logic [1:0] state;
  logic [3:0] pair_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  operand_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .load_btn(load_btn), .clear(clear),
    .op1(op1), .op2(op2), .ops_valid(ops_valid), .state(state), .pair_cnt(pair_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t required finish earlier", $time);
    $fatal(1);
  end

  // driver tasks
  task automatic press_btn(input logic [3:0] v);
    @(negedge clk);
    sw = v;
    load_btn = 1'b1;
    repeat (12) @(negedge clk);
    load_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw = 4'b0000; load_btn = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (op1 !== 4'h0) begin n_fail++; $display("FAIL reset_op1 got %b want 0000", op1); end
    n_checks++; if (op2 !== 4'h0) begin n_fail++; $display("FAIL reset_op2 got %b want 0000", op2); end
    n_checks++; if (ops_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ops_valid); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", state); end
    n_checks++; if (pair_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", pair_cnt); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_pair();
    press_btn(4'b1010);
    n_checks++; if (op1 !== 4'b1010) begin n_fail++; $display("FAIL first_op1 got %b want 1010", op1); end
    n_checks++; if (op2 !== 4'b0000) begin n_fail++; $display("FAIL first_op2 got %b want 0000", op2); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL first_state got %b want 01", state); end
    n_checks++; if (ops_valid !== 1'b0) begin n_fail++; $display("FAIL first_valid got %b want 0", ops_valid); end
    press_btn(4'b0110);
    n_checks++; if (op1 !== 4'b1010) begin n_fail++; $display("FAIL pair_op1 got %b want 1010", op1); end
    n_checks++; if (op2 !== 4'b0110) begin n_fail++; $display("FAIL pair_op2 got %b want 0110", op2); end
    n_checks++; if (ops_valid !== 1'b1) begin n_fail++; $display("FAIL pair_valid got %b want 1", ops_valid); end
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL pair_state got %b want 10", state); end
    n_checks++; if (pair_cnt !== 4'd1) begin n_fail++; $display("FAIL pair_cnt got %0d want 1", pair_cnt); end
    n_checks++; if ((op1 & op2) !== 4'b0010) begin n_fail++; $display("FAIL and_result got %b want 0010", op1 & op2); end
  endtask

  task automatic test_sw_change();
    @(negedge clk);
    sw = 4'b0101;
    repeat (10) @(negedge clk);
    n_checks++; if (op1 !== 4'b1010) begin n_fail++; $display("FAIL swchg_op1 got %b want 1010", op1); end
    n_checks++; if (op2 !== 4'b0110) begin n_fail++; $display("FAIL swchg_op2 got %b want 0110", op2); end
  endtask

  task automatic test_hold_restart();
    press_btn(4'b1111);
    n_checks++; if (op1 !== 4'b1111) begin n_fail++; $display("FAIL restart_op1 got %b want 1111", op1); end
    n_checks++; if (op2 !== 4'b0000) begin n_fail++; $display("FAIL restart_op2 got %b want 0000", op2); end
    n_checks++; if (ops_valid !== 1'b0) begin n_fail++; $display("FAIL restart_valid got %b want 0", ops_valid); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL restart_state got %b want 01", state); end
    n_checks++; if (pair_cnt !== 4'd1) begin n_fail++; $display("FAIL restart_cnt got %0d want 1", pair_cnt); end
  endtask

  // In LOAD_B with op1=1111: 3-cycle glitches, then a stable hold captured at edge 7.
  task automatic test_glitch();
    @(negedge clk);
    sw = 4'b1100;
    for (int g = 0; g < 3; g++) begin
      load_btn = 1'b1;
      repeat (3) @(negedge clk);
      load_btn = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL glitch_state got %b want 01", state); end
    n_checks++; if (op2 !== 4'b0000) begin n_fail++; $display("FAIL glitch_op2 got %b want 0000", op2); end
    load_btn = 1'b1;
    repeat (7) @(negedge clk);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL edge6_state got %b want 01", state); end
    @(negedge clk);
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL edge7_state got %b want 10", state); end
    n_checks++; if (op2 !== 4'b1100) begin n_fail++; $display("FAIL edge7_op2 got %b want 1100", op2); end
    n_checks++; if (pair_cnt !== 4'd2) begin n_fail++; $display("FAIL edge7_cnt got %0d want 2", pair_cnt); end
    repeat (12) @(negedge clk);
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL held_once_state got %b want 10", state); end
    load_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd2;
    for (int i = 0; i < 14; i++) begin
      press_btn(4'(i));
      press_btn(4'(i + 1));
      exp_cnt = exp_cnt + 4'd1;
      n_checks++; if (pair_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt[%0d] got %0d want %0d", i, pair_cnt, exp_cnt); end
    end
    n_checks++; if (pair_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_final got %0d want 0", pair_cnt); end
    n_checks++; if (ops_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", ops_valid); end
  endtask

  task automatic test_clear_with_press();
    press_btn(4'b0111);
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL preclr_state got %b want 01", state); end
    @(negedge clk);
    sw = 4'b1001;
    load_btn = 1'b1;
    repeat (7) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++; if (op1 !== 4'h0) begin n_fail++; $display("FAIL clr_op1 got %b want 0000", op1); end
    n_checks++; if (op2 !== 4'h0) begin n_fail++; $display("FAIL clr_op2 got %b want 0000", op2); end
    n_checks++; if (ops_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid got %b want 0", ops_valid); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL clr_state got %b want 00", state); end
    n_checks++; if (pair_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_cnt got %0d want 0", pair_cnt); end
    repeat (10) @(negedge clk);
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL clr_held_state got %b want 00", state); end
    n_checks++; if (op1 !== 4'h0) begin n_fail++; $display("FAIL clr_held_op1 got %b want 0000", op1); end
    load_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_async_reset();
    press_btn(4'b0001);
    press_btn(4'b0010);
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("FAIL prerst_state got %b want 10", state); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (op1 !== 4'h0) begin n_fail++; $display("FAIL arst_op1 got %b want 0000", op1); end
    n_checks++; if (op2 !== 4'h0) begin n_fail++; $display("FAIL arst_op2 got %b want 0000", op2); end
    n_checks++; if (ops_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b want 0", ops_valid); end
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("FAIL arst_state got %b want 00", state); end
    n_checks++; if (pair_cnt !== 4'd0) begin n_fail++; $display("FAIL arst_cnt got %0d want 0", pair_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    press_btn(4'b0011);
    n_checks++; if (op1 !== 4'b0011) begin n_fail++; $display("FAIL postrst_op1 got %b want 0011", op1); end
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("FAIL postrst_state got %b want 01", state); end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_sw_change();
    test_hold_restart();
    test_glitch();
    test_wrap();
    test_clear_with_press();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
